// File: rtl/vga_timing_gen.sv
// VGA raster timing (640x480 @ 60 Hz by default): pixel/line counters, registered blank/hs/vs decode,
// frame pulse and frame counter. Define VGA_SYNC_DELAY_EN to delay hs/vs by two extra clocks.
module vga_timing_gen #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       vga_clk,
    input  logic       reset_n,
    output logic [9:0] DrawX,
    output logic [9:0] DrawY,
    output logic       blank,
    output logic       hs,
    output logic       vs,
    output logic       frame_start,
    output logic [7:0] frame_cnt
);

    localparam logic [9:0] H_VIS    = 10'(H_ACTIVE);
    localparam logic [9:0] H_LAST   = 10'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
    localparam logic [9:0] HS_START = 10'(H_ACTIVE + H_FP);
    localparam logic [9:0] HS_END   = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] V_VIS    = 10'(V_ACTIVE);
    localparam logic [9:0] V_LAST   = 10'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
    localparam logic [9:0] VS_START = 10'(V_ACTIVE + V_FP);
    localparam logic [9:0] VS_END   = 10'(V_ACTIVE + V_FP + V_SYNC - 1);

    function automatic logic in_span(input logic [9:0] v, input logic [9:0] lo,
                                     input logic [9:0] hi);
        return (v >= lo) && (v <= hi);
    endfunction

    function automatic logic is_active(input logic [9:0] x, input logic [9:0] y);
        return (x < H_VIS) && (y < V_VIS);
    endfunction

    logic [9:0] hc_nxt;
    logic [9:0] vc_nxt;
    logic       h_wrap;
    logic       frame_wrap;
    logic       hs_p0;
    logic       vs_p0;

    // Decodes are taken from the next counter values so the registered flags line up with DrawX/DrawY.
    always_comb begin
        h_wrap     = (DrawX == H_LAST);
        frame_wrap = h_wrap && (DrawY == V_LAST);
        hc_nxt     = h_wrap ? 10'd0 : DrawX + 10'd1;
        vc_nxt     = DrawY;
        if (h_wrap) begin
            vc_nxt = frame_wrap ? 10'd0 : DrawY + 10'd1;
        end
    end

    // Stage p0: counters and aligned decodes
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            DrawX       <= 10'd0;
            DrawY       <= 10'd0;
            blank       <= 1'b1;
            hs_p0       <= 1'b1;
            vs_p0       <= 1'b1;
            frame_start <= 1'b0;
            frame_cnt   <= 8'd0;
        end else begin
            DrawX       <= hc_nxt;
            DrawY       <= vc_nxt;
            blank       <= is_active(hc_nxt, vc_nxt);
            hs_p0       <= !in_span(hc_nxt, HS_START, HS_END);
            vs_p0       <= !in_span(vc_nxt, VS_START, VS_END);
            frame_start <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

`ifdef VGA_SYNC_DELAY_EN
    logic hs_p1, hs_p2, vs_p1, vs_p2;

    // Stages p1/p2: sync delayed to match the mappers' ROM read + color register
    always_ff @(posedge vga_clk or negedge reset_n) begin
        if (!reset_n) begin
            hs_p1 <= 1'b1;
            hs_p2 <= 1'b1;
            vs_p1 <= 1'b1;
            vs_p2 <= 1'b1;
        end else begin
            hs_p1 <= hs_p0;
            hs_p2 <= hs_p1;
            vs_p1 <= vs_p0;
            vs_p2 <= vs_p1;
        end
    end

    assign hs = hs_p2;
    assign vs = vs_p2;
`else
    assign hs = hs_p0;
    assign vs = vs_p0;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen: a full-size instance for line-level timing and a shrunken instance
// for frame-level behaviour, both checked against an arithmetic raster model.
module tb_vga_timing_gen;

    localparam int B_HA = 640, B_HF = 16, B_HS = 96, B_HB = 48;
    localparam int B_VA = 480, B_VF = 10, B_VS = 2,  B_VB = 33;
    localparam int S_HA = 16,  S_HF = 4,  S_HS = 6,  S_HB = 4;
    localparam int S_VA = 12,  S_VF = 2,  S_VS = 2,  S_VB = 3;
    localparam int S_HT = S_HA + S_HF + S_HS + S_HB;   // 30
    localparam int S_VT = S_VA + S_VF + S_VS + S_VB;   // 19
`ifdef VGA_SYNC_DELAY_EN
    localparam int SYNC_LAG = 2;
`else
    localparam int SYNC_LAG = 0;
`endif

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [9:0] b_x, b_y, s_x, s_y;
    logic       b_blank, b_hs, b_vs, b_fs, s_blank, s_hs, s_vs, s_fs;
    logic [7:0] b_fc, s_fc;
    logic [31:0] b_act, s_act;
    int checks = 0;
    int errors = 0;
    int t = 0;

    always #5 clk = ~clk;

    vga_timing_gen u_big (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(b_x), .DrawY(b_y), .blank(b_blank),
        .hs(b_hs), .vs(b_vs), .frame_start(b_fs), .frame_cnt(b_fc)
    );

    vga_timing_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)
    ) u_small (
        .vga_clk(clk), .reset_n(reset_n), .DrawX(s_x), .DrawY(s_y), .blank(s_blank),
        .hs(s_hs), .vs(s_vs), .frame_start(s_fs), .frame_cnt(s_fc)
    );

    assign b_act = {b_x, b_y, b_blank, b_hs, b_vs, b_fs, b_fc};
    assign s_act = {s_x, s_y, s_blank, s_hs, s_vs, s_fs, s_fc};

    // Expected {x, y, blank, hs, vs, frame_start, frame_cnt} after t clocks since reset release.
    function automatic logic [31:0] model(input int tt, input int ha, input int hf, input int hsw,
                                          input int hb, input int va, input int vf, input int vsw,
                                          input int vb);
        int ht, vt, x, y, ts, xs, ys;
        logic bl, h, v, fs;
        logic [7:0] fc;
        ht = ha + hf + hsw + hb;
        vt = va + vf + vsw + vb;
        x  = tt % ht;
        y  = (tt / ht) % vt;
        bl = (x < ha) && (y < va);
        ts = tt - SYNC_LAG;
        h  = 1'b1;
        v  = 1'b1;
        if (ts >= 0) begin
            xs = ts % ht;
            ys = (ts / ht) % vt;
            h  = !(xs >= ha + hf && xs < ha + hf + hsw);
            v  = !(ys >= va + vf && ys < va + vf + vsw);
        end
        fs = (tt > 0) && (tt % (ht * vt) == 0);
        fc = 8'((tt / (ht * vt)) % 256);
        return {10'(x), 10'(y), bl, h, v, fs, fc};
    endfunction

    function automatic logic [31:0] model_b(input int tt);
        return model(tt, B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB);
    endfunction

    function automatic logic [31:0] model_s(input int tt);
        return model(tt, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB);
    endfunction

    task automatic apply_reset(input int hold);
        @(negedge clk);
        reset_n = 1'b0;
        repeat (hold) @(negedge clk);
        reset_n = 1'b1;
        t = 0;
    endtask

    task automatic test_reset;
        @(negedge clk);
        #2 reset_n = 1'b0;
        #1;
        checks++; if (b_x !== 10'd0) begin errors++; $display("FAIL reset_drawx got %0d exp 0", b_x); end
        checks++; if (b_y !== 10'd0) begin errors++; $display("FAIL reset_drawy got %0d exp 0", b_y); end
        checks++; if (b_blank !== 1'b1) begin errors++; $display("FAIL reset_blank got %b exp 1", b_blank); end
        checks++; if (b_hs !== 1'b1) begin errors++; $display("FAIL reset_hs got %b exp 1", b_hs); end
        checks++; if (b_vs !== 1'b1) begin errors++; $display("FAIL reset_vs got %b exp 1", b_vs); end
        checks++; if (b_fs !== 1'b0) begin errors++; $display("FAIL reset_fs got %b exp 0", b_fs); end
        checks++; if (b_fc !== 8'd0) begin errors++; $display("FAIL reset_fcnt got %0d exp 0", b_fc); end
        checks++; if (s_act !== model_s(0)) begin errors++; $display("FAIL reset_small got %h exp %h", s_act, model_s(0)); end
        apply_reset(3);
        checks++; if (b_act !== model_b(0)) begin errors++; $display("FAIL release_big got %h exp %h", b_act, model_b(0)); end
        @(negedge clk); t++;
        checks++; if (b_act !== model_b(1)) begin errors++; $display("FAIL first_edge got %h exp %h", b_act, model_b(1)); end
        checks++; if (s_act !== model_s(1)) begin errors++; $display("FAIL first_edge_small got %h exp %h", s_act, model_s(1)); end
    endtask

    task automatic test_line;
        int blank_cnt = 0, hs_low = 0, fall_x = -1, rise_x = -1;
        logic prev_hs = 1'b1;
        apply_reset(2);
        while (t <= 805) begin
            checks++; if (b_act !== model_b(t)) begin errors++; $display("FAIL line_big t=%0d got %h exp %h", t, b_act, model_b(t)); end
            if (t < 800) begin
                if (b_blank) blank_cnt++;
                if (!b_hs) hs_low++;
                if (prev_hs && !b_hs) fall_x = int'(b_x);
                if (!prev_hs && b_hs) rise_x = int'(b_x);
            end
            prev_hs = b_hs;
            @(negedge clk); t++;
        end
        checks++; if (blank_cnt != 640) begin errors++; $display("FAIL line_blank_cnt got %0d exp 640", blank_cnt); end
        checks++; if (hs_low != 96) begin errors++; $display("FAIL line_hs_low got %0d exp 96", hs_low); end
        checks++; if (fall_x != 656 + SYNC_LAG) begin errors++; $display("FAIL hs_fall_x got %0d exp %0d", fall_x, 656 + SYNC_LAG); end
        checks++; if (rise_x != 752 + SYNC_LAG) begin errors++; $display("FAIL hs_rise_x got %0d exp %0d", rise_x, 752 + SYNC_LAG); end
    endtask

    task automatic test_frames;
        int pulses = 0, last_pulse = 0, vs_low = 0, bad_blank = 0;
        apply_reset(1);
        while (t <= 3 * S_HT * S_VT + 10) begin
            checks++; if (s_act !== model_s(t)) begin errors++; $display("FAIL frame_small t=%0d got %h exp %h", t, s_act, model_s(t)); end
            if (t < S_HT * S_VT && !s_vs) vs_low++;
            if (s_y >= 10'(S_VA) && s_blank) bad_blank++;
            if (s_fs) begin
                pulses++;
                checks++; if (s_fc !== 8'(pulses)) begin errors++; $display("FAIL frame_cnt_at_pulse got %0d exp %0d", s_fc, pulses); end
                checks++; if (t - last_pulse != S_HT * S_VT) begin errors++; $display("FAIL pulse_spacing got %0d exp %0d", t - last_pulse, S_HT * S_VT); end
                checks++; if (s_x !== 10'd0 || s_y !== 10'd0) begin errors++; $display("FAIL pulse_pos got (%0d,%0d) exp (0,0)", s_x, s_y); end
                last_pulse = t;
            end
            @(negedge clk); t++;
        end
        checks++; if (pulses != 3) begin errors++; $display("FAIL pulse_count got %0d exp 3", pulses); end
        checks++; if (vs_low != S_VS * S_HT) begin errors++; $display("FAIL vs_low_cnt got %0d exp %0d", vs_low, S_VS * S_HT); end
        checks++; if (bad_blank != 0) begin errors++; $display("FAIL blank_in_vblank got %0d exp 0", bad_blank); end
    endtask

    task automatic test_mid_sync_reset;
        int target;
        apply_reset(1);
        while (t < 700) begin @(negedge clk); t++; end
        checks++; if (b_hs !== 1'b0) begin errors++; $display("FAIL pre_reset_hs got %b exp 0", b_hs); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if ({b_x, b_y, b_blank, b_hs, b_vs, b_fc} !== {20'd0, 3'b111, 8'd0})
            begin errors++; $display("FAIL midline_reset got %h exp %h", {b_x, b_y, b_blank, b_hs, b_vs, b_fc}, {20'd0, 3'b111, 8'd0}); end
        apply_reset(1);
        target = (S_VA + S_VF + 1) * S_HT + S_HA + S_HF + 2;
        while (t < target) begin @(negedge clk); t++; end
        checks++; if ({s_hs, s_vs} !== 2'b00) begin errors++; $display("FAIL pre_reset_sync got %b exp 00", {s_hs, s_vs}); end
        #2 reset_n = 1'b0;
        #1;
        checks++; if (s_act !== model_s(0)) begin errors++; $display("FAIL midsync_reset got %h exp %h", s_act, model_s(0)); end
    endtask

    task automatic test_random_runs;
        for (int i = 0; i < 5; i++) begin
            int len;
            len = int'($urandom_range(50, 1500));
            apply_reset(int'($urandom_range(1, 4)));
            while (t < len) begin
                checks++; if (s_act !== model_s(t)) begin errors++; $display("FAIL rand_small t=%0d got %h exp %h", t, s_act, model_s(t)); end
                checks++; if (b_act !== model_b(t)) begin errors++; $display("FAIL rand_big t=%0d got %h exp %h", t, b_act, model_b(t)); end
                @(negedge clk); t++;
            end
            #($urandom_range(1, 3)) reset_n = 1'b0;
            #1;
            checks++; if (b_act !== model_b(0)) begin errors++; $display("FAIL rand_reset got %h exp %h", b_act, model_b(0)); end
        end
    endtask

    initial begin
        #5ms;
        $display("FAIL watchdog timeout reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_line();
        test_frames();
        test_mid_sync_reset();
        test_random_runs();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
